// File: rtl/regfile_dump_reader.sv
// Streams register-file words FIRST_ADDR..LAST_ADDR over a valid/ready port,
// one FETCH cycle plus at least one SEND cycle per word.
module regfile_dump_reader #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rfAddr_q, rfAddr_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                last_q, last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rfAddr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rfAddr_q <= rfAddr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
        end
    end

    // The word is captured in FETCH; later register-file writes do not alter the beat.
    always_comb begin
        state_d  = state_q;
        rfAddr_d = rfAddr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        addr_d   = addr_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rfAddr_d = FirstAddr;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                data_d  = rf_data;
                addr_d  = rfAddr_q;
                last_d  = (rfAddr_q == LastAddr);
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        rfAddr_d = rfAddr_q + ADDR_W'(1);
                        state_d  = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rf_addr   = rfAddr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: a cycle table for reset and the first beats, then full dumps
// with backpressure, ignored restart, mid-dump reset and a single-entry range.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, outReady;
    logic [4:0]  rfAddr, outAddr;
    logic [31:0] rfData, outData;
    logic        outValid, outLast, busy, done;

    logic        start7, outReady7;
    logic [4:0]  rfAddr7, outAddr7;
    logic [31:0] rfData7, outData7;
    logic        outValid7, outLast7, busy7, done7;

    logic [31:0] regs [32];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign rfData  = regs[rfAddr];
    assign rfData7 = regs[rfAddr7];

    regfile_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .rf_addr(rfAddr), .rf_data(rfData),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData),
        .out_addr(outAddr), .out_last(outLast), .busy(busy), .done(done)
    );

    regfile_dump_reader #(.FIRST_ADDR(7), .LAST_ADDR(7)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .rf_addr(rfAddr7), .rf_data(rfData7),
        .out_valid(outValid7), .out_ready(outReady7), .out_data(outData7),
        .out_addr(outAddr7), .out_last(outLast7), .busy(busy7), .done(done7)
    );

    typedef struct {
        logic        rst, start, ready;
        logic        expValid, expBusy, expDone, expLast;
        logic [4:0]  expAddr, expRfAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        start    = v.start;
        outReady = v.ready;
        step();
    endtask

    // Runs one dump from IDLE; t counts edges after the start edge N.
    task automatic runDump(input string tag, input int stallBeat, input int stallCycles,
                           input int restartBeat, input int expDoneT);
        int beats = 0, dones = 0, doneT = -1, busyFallT = -1, stalls = 0;
        start    = 1'b1;
        outReady = 1'b1;
        step();
        for (int t = 0; t < 90; t++) begin
            start    = 1'b0;
            outReady = 1'b1;
            if (done) begin
                dones++;
                doneT = t;
            end
            if (!busy && busyFallT < 0) busyFallT = t;
            if (outValid) begin
                if (beats == restartBeat) start = 1'b1;
                if (beats == stallBeat && stalls < stallCycles) begin
                    outReady = 1'b0;
                    stalls++;
                    checkOutput({tag, ".stallAddr"}, 32'(outAddr), 32'(beats));
                    checkOutput({tag, ".stallData"}, outData, regs[beats % 32]);
                end else begin
                    checkOutput({tag, ".addr"}, 32'(outAddr), 32'(beats));
                    checkOutput({tag, ".data"}, outData, regs[beats % 32]);
                    checkOutput({tag, ".last"}, 32'(outLast), 32'(beats == 31));
                    beats++;
                end
            end
            step();
        end
        start = 1'b0;
        checkOutput({tag, ".beats"}, 32'(beats), 32'd32);
        checkOutput({tag, ".doneCount"}, 32'(dones), 32'd1);
        checkOutput({tag, ".doneCycle"}, 32'(doneT), 32'(expDoneT));
        checkOutput({tag, ".busyFall"}, 32'(busyFallT), 32'(expDoneT + 1));
        checkOutput({tag, ".idleValid"}, 32'(outValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;
        rst = 1'b1; start = 1'b0; outReady = 1'b0; start7 = 1'b0; outReady7 = 1'b0;

        // rst, start, ready | valid, busy, done, last | addr, rfAddr, data
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd1, 32'h0101_0101};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d.valid", i), 32'(outValid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d.last", i), 32'(outLast), 32'(vecs[i].expLast));
            checkOutput($sformatf("vec%0d.addr", i), 32'(outAddr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d.rfAddr", i), 32'(rfAddr), 32'(vecs[i].expRfAddr));
            checkOutput($sformatf("vec%0d.data", i), outData, vecs[i].expData);
        end

        runDump("full", -1, 0, -1, 64);
        runDump("stall", 5, 3, -1, 67);
        runDump("restart", -1, 0, 10, 64);

        // Reset while beat 12 is held under backpressure.
        start = 1'b1; outReady = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (outValid && outAddr == 5'd12) found = 1'b1;
            else step();
        end
        checkOutput("midReset.reachBeat12", 32'(found), 32'd1);
        outReady = 1'b0;
        step();
        checkOutput("midReset.heldValid", 32'(outValid), 32'd1);
        checkOutput("midReset.heldData", outData, 32'h0c0c_0c0c);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midReset.valid", 32'(outValid), 32'd0);
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        checkOutput("midReset.addr", 32'(outAddr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("midReset.noDone", 32'(done), 32'd0);
            step();
        end
        runDump("afterReset", -1, 0, -1, 64);

        // Single-entry range on the second instance.
        start7 = 1'b1; outReady7 = 1'b1;
        step();
        start7 = 1'b0;
        checkOutput("single.busy", 32'(busy7), 32'd1);
        checkOutput("single.rfAddr", 32'(rfAddr7), 32'd7);
        checkOutput("single.validEarly", 32'(outValid7), 32'd0);
        step();
        checkOutput("single.valid", 32'(outValid7), 32'd1);
        checkOutput("single.addr", 32'(outAddr7), 32'd7);
        checkOutput("single.data", outData7, 32'h0707_0707);
        checkOutput("single.last", 32'(outLast7), 32'd1);
        step();
        checkOutput("single.done", 32'(done7), 32'd1);
        checkOutput("single.validAfter", 32'(outValid7), 32'd0);
        step();
        checkOutput("single.doneOnce", 32'(done7), 32'd0);
        checkOutput("single.idle", 32'(busy7), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
